// File: rtl/load_store_unit.sv
// Load/store unit between the datapath and a word-only data memory.
// Sub-word loads are extracted and extended; sub-word stores use a read-modify-write.
module load_store_unit #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W+1:0] byte_addr,
    input  logic [31:0]       store_data,
    output logic [31:0]       load_data,
    output logic              stall,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic {
        IDLE,
        WR
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       old_q, old_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [1:0]        lane_q, lane_d;
    logic              half_q, half_d;
    logic [15:0]       sdata_q, sdata_d;

    logic [1:0]  lane;
    logic        unaligned;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ext;
    logic [31:0] merged;

    // Lane selection, extension of read data and merge of the held old word
    always_comb begin
        lane      = byte_addr[1:0];
        unaligned = ((size == 2'b01) && lane[0])
                  || (size[1] && (lane != 2'b00));
        rd_byte   = mem_rdata[{lane, 3'b000} +: 8];
        rd_half   = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ext       = 32'h0;
        unique case (size)
            2'b00:   ext = {{24{~uns & rd_byte[7]}}, rd_byte};
            2'b01:   ext = {{16{~uns & rd_half[15]}}, rd_half};
            default: ext = mem_rdata;
        endcase
        merged = old_q;
        if (half_q) begin
            merged[{lane_q[1], 4'b0000} +: 16] = sdata_q;
        end else begin
            merged[{lane_q, 3'b000} +: 8] = sdata_q[7:0];
        end
    end

    // Next state and outputs; reset blanks all strobes immediately
    always_comb begin
        state_d   = state_q;
        old_d     = old_q;
        waddr_d   = waddr_q;
        lane_d    = lane_q;
        half_d    = half_q;
        sdata_d   = sdata_q;
        load_data = 32'h0;
        stall     = 1'b0;
        misalign  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = 32'h0;
        mem_addr  = byte_addr[ADDR_W+1:2];
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (unaligned) begin
                        misalign = 1'b1;
                    end else if (!we) begin
                        load_data = ext;
                    end else if (size[1]) begin
                        mem_write = 1'b1;
                        mem_wdata = store_data;
                    end else begin
                        stall   = 1'b1;
                        state_d = WR;
                        old_d   = mem_rdata;
                        waddr_d = byte_addr[ADDR_W+1:2];
                        lane_d  = lane;
                        half_d  = size[0];
                        sdata_d = store_data[15:0];
                    end
                end
            end
            WR: begin
                mem_addr  = waddr_q;
                mem_write = 1'b1;
                mem_wdata = merged;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            load_data = 32'h0;
            stall     = 1'b0;
            misalign  = 1'b0;
            mem_write = 1'b0;
            mem_wdata = 32'h0;
        end
    end

    // State and captured read-modify-write context
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            old_q   <= 32'h0;
            waddr_q <= '0;
            lane_q  <= 2'b00;
            half_q  <= 1'b0;
            sdata_q <= 16'h0;
        end else begin
            state_q <= state_d;
            old_q   <= old_d;
            waddr_q <= waddr_d;
            lane_q  <= lane_d;
            half_q  <= half_d;
            sdata_q <= sdata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural word memory.
// Table of single-cycle accesses plus hand-written multi-cycle store sequences.
module tb_load_store_unit;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W+1:0] byte_addr;
    logic [31:0]       store_data;
    logic [31:0]       load_data;
    logic              stall;
    logic              misalign;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_write;
    logic [31:0]       mem_rdata;

    logic [31:0] mem [64];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    // Word-only data memory, written on the rising edge
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
    end

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .we         (we),
        .size       (size),
        .uns        (uns),
        .byte_addr  (byte_addr),
        .store_data (store_data),
        .load_data  (load_data),
        .stall      (stall),
        .misalign   (misalign),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        string       name;
        logic        req;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [7:0]  addr;
        logic [31:0] sd;
        logic [31:0] e_ld;
        logic        e_stall;
        logic        e_mis;
        logic        e_mw;
        logic [31:0] e_wd;
        logic [5:0]  e_ma;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [1:0] s,
                         input logic u, input logic [7:0] a,
                         input logic [31:0] d);
        req        = r;
        we         = w;
        size       = s;
        uns        = u;
        byte_addr  = a;
        store_data = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            name         rq we sz    u  addr   sdata          load           st mis mw wdata          ma
        vecs[0]  = '{"idle",       0, 0, 2'b00,0, 8'd13, 32'h12345678, 32'h00000000, 0, 0, 0, 32'h00000000, 6'd3};
        vecs[1]  = '{"lb_13",      1, 0, 2'b00,0, 8'd13, 32'h0,        32'hFFFFFFAA, 0, 0, 0, 32'h00000000, 6'd3};
        vecs[2]  = '{"lbu_13",     1, 0, 2'b00,1, 8'd13, 32'h0,        32'h000000AA, 0, 0, 0, 32'h00000000, 6'd3};
        vecs[3]  = '{"lb_14",      1, 0, 2'b00,0, 8'd14, 32'h0,        32'hFFFFFF99, 0, 0, 0, 32'h00000000, 6'd3};
        vecs[4]  = '{"lbu_15",     1, 0, 2'b00,1, 8'd15, 32'h0,        32'h00000088, 0, 0, 0, 32'h00000000, 6'd3};
        vecs[5]  = '{"lh_12",      1, 0, 2'b01,0, 8'd12, 32'h0,        32'hFFFFAABB, 0, 0, 0, 32'h00000000, 6'd3};
        vecs[6]  = '{"lhu_14",     1, 0, 2'b01,1, 8'd14, 32'h0,        32'h00008899, 0, 0, 0, 32'h00000000, 6'd3};
        vecs[7]  = '{"lw_12_uns",  1, 0, 2'b10,1, 8'd12, 32'h0,        32'h8899AABB, 0, 0, 0, 32'h00000000, 6'd3};
        vecs[8]  = '{"sw_8",       1, 1, 2'b10,0, 8'd8,  32'hDEADBEEF, 32'h00000000, 0, 0, 1, 32'hDEADBEEF, 6'd2};
        vecs[9]  = '{"lw_8",       1, 0, 2'b10,0, 8'd8,  32'h0,        32'hDEADBEEF, 0, 0, 0, 32'h00000000, 6'd2};
        vecs[10] = '{"lh_5_mis",   1, 0, 2'b01,0, 8'd5,  32'h0,        32'h00000000, 0, 1, 0, 32'h00000000, 6'd1};
        vecs[11] = '{"sw_6_mis",   1, 1, 2'b10,0, 8'd6,  32'h55555555, 32'h00000000, 0, 1, 0, 32'h00000000, 6'd1};
        vecs[12] = '{"lw_top",     1, 0, 2'b11,0, 8'd252,32'h0,        32'hCAFEF00D, 0, 0, 0, 32'h00000000, 6'd63};
        vecs[13] = '{"lw_4_after", 1, 0, 2'b10,0, 8'd4,  32'h0,        32'h01020304, 0, 0, 0, 32'h00000000, 6'd1};

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0]  = 32'h11223344;
        mem[1]  = 32'h01020304;
        mem[3]  = 32'h8899AABB;
        mem[63] = 32'hCAFEF00D;

        // Reset state with a live load request on the inputs
        reset = 1'b1;
        drive(1, 0, 2'b00, 0, 8'd13, 32'h0);
        #2;
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_misalign", {31'h0, misalign}, 32'h0);
        chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
        next_cycle();
        reset = 1'b0;
        drive(0, 0, 2'b00, 0, 8'd0, 32'h0);
        next_cycle();

        // Single-cycle accesses
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].req, vecs[i].we, vecs[i].size, vecs[i].uns,
                  vecs[i].addr, vecs[i].sd);
            #2;
            chk({vecs[i].name, ".load_data"}, load_data, vecs[i].e_ld);
            chk({vecs[i].name, ".stall"}, {31'h0, stall}, {31'h0, vecs[i].e_stall});
            chk({vecs[i].name, ".misalign"}, {31'h0, misalign}, {31'h0, vecs[i].e_mis});
            chk({vecs[i].name, ".mem_write"}, {31'h0, mem_write}, {31'h0, vecs[i].e_mw});
            chk({vecs[i].name, ".mem_addr"}, {26'h0, mem_addr}, {26'h0, vecs[i].e_ma});
            if (vecs[i].e_mw) chk({vecs[i].name, ".mem_wdata"}, mem_wdata, vecs[i].e_wd);
            next_cycle();
        end
        chk("mis_mem_unchanged", mem[1], 32'h01020304);

        // SB 0x12 at byte 14 over word 3
        drive(1, 1, 2'b00, 0, 8'd14, 32'h00000012);
        #2;
        chk("sb14_stall", {31'h0, stall}, 32'h1);
        chk("sb14_nowrite", {31'h0, mem_write}, 32'h0);
        next_cycle();
        #2;
        chk("sb14_wr_stall", {31'h0, stall}, 32'h0);
        chk("sb14_wr_write", {31'h0, mem_write}, 32'h1);
        chk("sb14_wr_addr", {26'h0, mem_addr}, 32'd3);
        chk("sb14_wr_wdata", mem_wdata, 32'h8812AABB);
        next_cycle();
        drive(1, 0, 2'b10, 0, 8'd12, 32'h0);
        #2;
        chk("sb14_lw12", load_data, 32'h8812AABB);
        chk("sb14_lw12_nowrite", {31'h0, mem_write}, 32'h0);
        next_cycle();

        // SH 0x3456 at byte 2 then back-to-back SB 0x77 at byte 1
        drive(1, 1, 2'b01, 0, 8'd2, 32'h00003456);
        #2;
        chk("sh2_stall", {31'h0, stall}, 32'h1);
        next_cycle();
        #2;
        chk("sh2_wr_write", {31'h0, mem_write}, 32'h1);
        chk("sh2_wr_wdata", mem_wdata, 32'h34563344);
        next_cycle();
        drive(1, 1, 2'b00, 0, 8'd1, 32'h00000077);
        #2;
        chk("sb1_stall", {31'h0, stall}, 32'h1);
        chk("sb1_nowrite", {31'h0, mem_write}, 32'h0);
        next_cycle();
        #2;
        chk("sb1_wr_write", {31'h0, mem_write}, 32'h1);
        chk("sb1_wr_wdata", mem_wdata, 32'h34567744);
        next_cycle();
        drive(0, 0, 2'b00, 0, 8'd0, 32'h0);
        #2;
        chk("word0_after_sh_sb", mem[0], 32'h34567744);
        chk("idle_after_sb_stall", {31'h0, stall}, 32'h0);
        next_cycle();

        // SB at byte 0 aborted by reset in WR
        drive(1, 1, 2'b00, 0, 8'd0, 32'h000000AB);
        #2;
        chk("sb0_stall", {31'h0, stall}, 32'h1);
        next_cycle();
        reset = 1'b1;
        #1;
        chk("abort_mem_write", {31'h0, mem_write}, 32'h0);
        chk("abort_stall", {31'h0, stall}, 32'h0);
        drive(1, 0, 2'b01, 0, 8'd5, 32'h0);
        #1;
        chk("abort_misalign", {31'h0, misalign}, 32'h0);
        drive(1, 0, 2'b00, 0, 8'd13, 32'h0);
        #1;
        chk("abort_load_data", load_data, 32'h0);
        next_cycle();
        chk("abort_word0", mem[0], 32'h34567744);
        reset = 1'b0;
        drive(1, 0, 2'b10, 0, 8'd0, 32'h0);
        #2;
        chk("post_abort_idle_stall", {31'h0, stall}, 32'h0);
        chk("post_abort_idle_write", {31'h0, mem_write}, 32'h0);
        chk("post_abort_lw0", load_data, 32'h34567744);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
